// File: rtl/bus_rcv.sv
// ---------------------------------------------------------------------------
// bus_rcv : receiving end of the pulse-strobed bus.
//
// This block detects the leading edge of a strobe, waits SETTLE cycles and
// then latches the data bus into a holding register. The latch either
// overwrites the register (jam) or ORs the bus into it. It then emits a
// one-cycle rdy pulse, followed ACK_DLY cycles later by a one-cycle ack
// pulse back to the sender. A second strobe edge that arrives during a
// transaction sets the sticky ovr flag. A strobe that drops before the latch
// edge sets the sticky short flag.
//
// Parameters
//   WIDTH   : data bus / holding register width
//   SETTLE  : cycles between edge detection and latch (0..15)
//   ACK_DLY : cycles from latch edge to ack pulse (1..255)
//
// Ports
//   clk    in   system clock
//   reset  in   asynchronous, active-high reset
//   strb   in   strobe from the sending driver (pulse or level)
//   bus    in   data bus, valid at the latch edge
//   mode   in   0 = jam, 1 = OR-in; sampled at the latch edge
//   clr    in   synchronous clear of data, ovr and short
//   data   out  holding register
//   rdy    out  one-cycle pulse, data updated
//   ack    out  one-cycle acknowledge pulse to the sender
//   busy   out  transaction in progress
//   ovr    out  sticky overrun flag
//   short  out  sticky short-strobe flag
// ---------------------------------------------------------------------------
module bus_rcv #(
  parameter int unsigned WIDTH   = 36,
  parameter int unsigned SETTLE  = 1,
  parameter int unsigned ACK_DLY = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strb,
  input  logic [WIDTH-1:0] bus,
  input  logic             mode,
  input  logic             clr,
  output logic [WIDTH-1:0] data,
  output logic             rdy,
  output logic             ack,
  output logic             busy,
  output logic             ovr,
  output logic             short
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_LATCH   = 2'd2;
  localparam logic [1:0] ST_ACKWAIT = 2'd3;

  localparam logic [3:0] SETTLE_INIT = 4'((SETTLE > 32'd0) ? (SETTLE - 32'd1) : 32'd0);
  localparam logic [7:0] ACK_INIT    = 8'(ACK_DLY - 32'd1);
  localparam bit         SETTLE_ZERO = (SETTLE == 32'd0);

  logic [1:0]       s_r;
  logic [1:0]       state_r, state_s;
  logic [3:0]       cnt_r, cnt_s;
  logic [7:0]       acnt_r, acnt_s;
  logic [WIDTH-1:0] data_r, data_s;
  logic             rdy_r, ack_r, busy_r, ovr_r, short_r;
  logic             ack_s, busy_s, ovr_s, short_s;
  logic             rise_s, latch_s, ovr_ev_s, short_ev_s;

  // A strobe held high across reset release still yields one rise, because
  // the shift register restarts from zero.
  assign rise_s = s_r[0] & ~s_r[1];

  // Next-state, counter, holding-register and flag computation.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    acnt_s     = acnt_r;
    latch_s    = 1'b0;
    ack_s      = 1'b0;
    short_ev_s = 1'b0;
    ovr_ev_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rise_s) begin
          if (SETTLE_ZERO) begin
            latch_s = 1'b1;
          end else begin
            state_s = ST_SETTLE;
            cnt_s   = SETTLE_INIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        // The strobe must still be high at every edge up to the latch edge.
        short_ev_s = ~s_r[0];
        if (cnt_r == 4'd0) begin
          latch_s = 1'b1;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_LATCH, ST_ACKWAIT: begin
        // The LATCH cycle already counts toward the ack delay.
        if (acnt_r == 8'd0) begin
          ack_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          acnt_s  = acnt_r - 8'd1;
          state_s = ST_ACKWAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // The data update happens on the edge that enters LATCH.
    if (latch_s) begin
      state_s = ST_LATCH;
      acnt_s  = ACK_INIT;
    end else begin
      acnt_s  = acnt_s;
    end

    if (rise_s && (state_r != ST_IDLE)) begin
      ovr_ev_s = 1'b1;
    end else begin
      ovr_ev_s = 1'b0;
    end

    // A clear that lands on the latch edge behaves as a jam.
    if (latch_s) begin
      if (clr || !mode) begin
        data_s = bus;
      end else begin
        data_s = data_r | bus;
      end
    end else if (clr) begin
      data_s = {WIDTH{1'b0}};
    end else begin
      data_s = data_r;
    end

    busy_s  = (state_s != ST_IDLE);
    ovr_s   = ovr_ev_s   | (ovr_r   & ~clr);
    short_s = short_ev_s | (short_r & ~clr);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_r     <= 2'b00;
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      acnt_r  <= 8'd0;
      data_r  <= {WIDTH{1'b0}};
      rdy_r   <= 1'b0;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
      ovr_r   <= 1'b0;
      short_r <= 1'b0;
    end else begin
      s_r     <= {s_r[0], strb};
      state_r <= state_s;
      cnt_r   <= cnt_s;
      acnt_r  <= acnt_s;
      data_r  <= data_s;
      rdy_r   <= latch_s;
      ack_r   <= ack_s;
      busy_r  <= busy_s;
      ovr_r   <= ovr_s;
      short_r <= short_s;
    end
  end

  assign data  = data_r;
  assign rdy   = rdy_r;
  assign ack   = ack_r;
  assign busy  = busy_r;
  assign ovr   = ovr_r;
  assign short = short_r;

endmodule

// File: doc/bus_rcv.md
Name: bus_rcv

Overview:
- Receiving end of the pulse-strobed bus used by the bus-driver and delay primitives.
- Detects the leading edge of a strobe pulse, which may be single-cycle or stretched over several cycles.
- Waits a settle interval, then latches the data bus into a holding register, either jam (overwrite) or OR-in.
- Emits a single-cycle ready pulse at latch and a delayed single-cycle acknowledge pulse back to the sender, completing the pulse handshake.
- Flags overrun and short strobes.

Parameters:
WIDTH, 36, data bus and holding register width.
SETTLE, 1, cycles between strobe edge detection and latch; legal 0..15.
ACK_DLY, 4, cycles from latch edge to ack pulse; legal 1..255.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
strb  input  1  strobe from the sending driver; level or pulse, any width ≥1 cycle.
bus  input  WIDTH  data bus; must be valid at the latch edge.
mode  input  1  0 = jam (data <= bus), 1 = OR (data <= data | bus); sampled at the latch edge.
clr  input  1  synchronous clear pulse for data, ovr and short.
data  output  WIDTH  holding register.
rdy  output  1  single-cycle pulse, data updated.
ack  output  1  single-cycle acknowledge pulse to the sender.
busy  output  1  level, transaction in progress.
ovr  output  1  sticky overrun flag.
short  output  1  sticky short-strobe flag.

Behaviour:
- Reset: async; all outputs 0, edge-detect regs 0, state IDLE, counters 0. A reset mid-transaction aborts it with no rdy/ack.
- Edge detect: two-stage shift s <= {s[0], strb}; rise = s[0] & !s[1].
  - A strobe held high across reset release counts as one rise.
  - A multi-cycle strobe produces exactly one rise.
- Timing: let E0 be the edge where s[0] first samples strb=1.
  - Latch edge L = E0 + 1 + SETTLE.
  - rdy = 1 for the cycle after L.
  - ack = 1 for the cycle after L + ACK_DLY.
- States:
  - IDLE: on rise, go to SETTLE if SETTLE > 0 (cnt <= SETTLE - 1), else go to LATCH directly at E0+1.
  - SETTLE: cnt decrements each cycle; at cnt = 0, go to LATCH.
  - LATCH: one cycle; update data per mode; set rdy; acnt <= ACK_DLY - 1; go to ACKWAIT.
  - ACKWAIT: acnt decrements each cycle; at acnt = 0, pulse ack and go to IDLE.
- busy: high from E0+1 until the ack edge. busy = 0 during the ack cycle, so a rise in the ack cycle starts a new transaction.
- Overrun: a rise while busy sets ovr and is otherwise ignored. The data and timing of the current transaction are unaffected.
- Short strobe: s[0] = 0 at any edge between E0+1 and L inclusive sets short. The latch still occurs.
- clr:
  - Clears data, ovr and short at the next edge.
  - If clr coincides with the latch edge, data <= bus in both modes.
  - If clr coincides with a new ovr/short event, the flag ends set.
  - clr never aborts or delays a transaction.
- Width rules: counters sized for the maximum legal parameter values; no wrap occurs. OR mode is bitwise over WIDTH.

Test Plan:
- SETTLE=1, ACK_DLY=4, mode=0: strb 1 cycle, bus=0o123456701234 -> data=0o123456701234 at E0+2, rdy high exactly 1 cycle after E0+2, ack high 1 cycle after E0+6, busy high E0+1..E0+5.
- mode=1, data preset to 0o000000000777: strb with bus=0o777000000000 -> data=0o777000000777. Then clr -> data=0, ovr=0.
- Strobe held 4 cycles (bd2-style): exactly one rdy and one ack, short=0. Repeat with SETTLE=3 and a 1-cycle strobe -> short=1, data still latched.
- Second strb rise at E0+3 (busy) -> ovr=1, only one rdy/ack, data from the first strobe. Rise exactly in the ack cycle -> new transaction, ovr unchanged.
- Assert reset at E0+3 with strb held high -> all outputs 0, no ack. After release -> one transaction from the held strobe.
- SETTLE=0, ACK_DLY=1: latch at E0+1, rdy at E0+1, ack at E0+2. Back-to-back strobes every 3 cycles -> no ovr.
